nand_sweep_checker: RTL and testbench

//  Self-contained stimulus/check stage for the two-input NAND function block (s = ~a | ~b).
//  - Upstream side: drives every input combination onto the function block, in counting order.
//  - Downstream side: samples the block's response, compares it with the NAND expectation,
//    and counts mismatches.

---
 rtl/nand_sweep_checker.sv | 142 ++++++++++++++
 tb/tb_nand_sweep_checker.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_sweep_checker.sv
// -----------------------------------------------------------------------------
// nand_sweep_checker
//
// Purpose:
//   Clocked stimulus/check stage for a WIDTH-input NAND function block.
//   A sweep drives every input vector onto the block in counting order,
//   holds each vector for SETTLE cycles, and samples the block's response
//   on the last cycle of the hold. Each response is compared against the
//   NAND expectation (~&stim). The stage counts mismatching vectors and
//   remembers the first one that failed.
//
// Parameters:
//   WIDTH   number of function inputs; a sweep covers 2**WIDTH vectors
//   SETTLE  cycles each vector is held before its response is sampled (>=1)
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        begin a sweep; only looked at while idle
//   stim       out  WIDTH    vector driven to the function block
//   resp       in   1        function block output
//   busy       out  1        sweep in progress
//   done       out  1        sweep complete; held until the next accepted start
//   pass       out  1        done with no mismatches
//   err_count  out  WIDTH+1  mismatching vectors in the last sweep
//   fail_vec   out  WIDTH    first mismatching vector (meaningful when err_count!=0)
//
// Configuration:
//   SWEEP_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep
//                          (err_count=1, fail_vec=that vector, pass=0).
//                          When undefined, every vector is always swept.
// -----------------------------------------------------------------------------
module nand_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] fail_vec
);

  // Hold counter must be able to hold the value SETTLE itself.
  localparam int HW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            expected;
  logic            mismatch;
  logic            last_vec;

  // NAND generalised to WIDTH inputs: low only when every input is high.
  // The case-inequality makes an unknown response count as a mismatch.
  assign expected = ~&stim;
  assign mismatch = (resp !== expected);
  assign last_vec = &stim;

  // Single sweep state machine. The compare/advance step is folded into
  // the sample edge of HOLD, so moving to the next vector costs no cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stim      <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            stim      <= '0;
            hold_cnt  <= HW'(SETTLE);
            err_count <= '0;
            fail_vec  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end

        HOLD: begin
          if (hold_cnt == HW'(1)) begin
            // Last cycle of this vector's hold: sample and judge it.
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) begin
                fail_vec <= stim;
              end
            end
`ifdef SWEEP_STOP_ON_FAIL_EN
            if (mismatch || last_vec) begin
              state <= FIN;
            end else begin
              stim     <= stim + 1'b1;
              hold_cnt <= HW'(SETTLE);
            end
`else
            if (last_vec) begin
              state <= FIN;
            end else begin
              stim     <= stim + 1'b1;
              hold_cnt <= HW'(SETTLE);
            end
`endif
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        FIN: begin
          // err_count already includes the final sample at this point.
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0);
          stim  <= '0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_nand_sweep_checker
//
// Purpose:
//   Self-checking bench for nand_sweep_checker. Two instances share clock and
//   reset: dut0 with SETTLE=1 and dut1 with SETTLE=3. Each instance's function
//   block is modelled as a response table indexed by stim. When a sweep is
//   issued, the expected result is computed from the table and pushed into
//   a per-instance queue; a monitor pops and compares whenever done rises.
// -----------------------------------------------------------------------------
module tb_nand_sweep_checker;

  localparam int W  = 2;
  localparam int N  = 1 << W;
  localparam int S0 = 1;
  localparam int S1 = 3;

  typedef struct {
    logic [31:0] err;
    logic [31:0] fvec;
    logic [31:0] lat;
    logic [31:0] nvec;
    logic [31:0] sig;
    logic        pass;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start0, start1;
  logic [W-1:0] stim0, stim1;
  logic         resp0, resp1;
  logic         busy0, busy1;
  logic         done0, done1;
  logic         pass0, pass1;
  logic [W:0]   err_count0, err_count1;
  logic [W-1:0] fail_vec0, fail_vec1;
  logic [N-1:0] tab0, tab1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Monitor bookkeeping per instance.
  logic        prev_busy[2];
  logic        prev_done[2];
  int          cyc[2];
  logic [31:0] seen_n[2];
  logic [31:0] seen_sig[2];
  logic [W-1:0] last_v[2];

  // Function block models: response looked up from a table by vector.
  assign resp0 = tab0[stim0];
  assign resp1 = tab1[stim1];

  nand_sweep_checker #(.WIDTH(W), .SETTLE(S0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start0),
    .stim      (stim0),
    .resp      (resp0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err_count0),
    .fail_vec  (fail_vec0)
  );

  nand_sweep_checker #(.WIDTH(W), .SETTLE(S1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .stim      (stim1),
    .resp      (resp1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err_count1),
    .fail_vec  (fail_vec1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: NAND is 0 only for the all-ones vector. Walk the vectors in
  // order, note which ones the table answers wrongly, and derive the result.
  function automatic exp_t model(input logic [N-1:0] tab, input int settle);
    exp_t e;
    e = '{default: 0};
    for (int v = 0; v < N; v++) begin
      e.nvec = e.nvec + 1;
      e.sig  = (e.sig << W) | 32'(v);
      if (tab[v] !== logic'(v != N - 1)) begin
        if (e.err == 0) e.fvec = 32'(v);
        e.err = e.err + 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    e.pass = (e.err == 0);
    e.lat  = e.nvec * 32'(settle) + 1;
    return e;
  endfunction

  // Monitor step for one instance: tracks latency from accept (busy rise)
  // and the sequence of distinct vectors driven, then scores on done rise.
  task automatic mon(input int d, input logic b, input logic dn, input logic [W-1:0] s,
                     input logic [W:0] ec, input logic [W-1:0] fv, input logic ps);
    exp_t e;
    if (b && !prev_busy[d]) begin
      cyc[d]      = 0;
      seen_n[d]   = 0;
      seen_sig[d] = 0;
    end else begin
      cyc[d]++;
    end
    if (b && (seen_n[d] == 0 || s != last_v[d])) begin
      seen_n[d]   = seen_n[d] + 1;
      seen_sig[d] = (seen_sig[d] << W) | 32'(s);
      last_v[d]   = s;
    end
    if (dn && !prev_done[d]) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done dut%0d: got done=1, expected no sweep completion", d);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check_output($sformatf("dut%0d err_count", d), 32'(ec), e.err);
        check_output($sformatf("dut%0d fail_vec", d), 32'(fv), e.fvec);
        check_output($sformatf("dut%0d pass", d), 32'(ps), 32'(e.pass));
        check_output($sformatf("dut%0d latency", d), 32'(cyc[d]), e.lat);
        check_output($sformatf("dut%0d vec_count", d), seen_n[d], e.nvec);
        check_output($sformatf("dut%0d vec_order", d), seen_sig[d], e.sig);
      end
    end
    prev_busy[d] = b;
    prev_done[d] = dn;
  endtask

  // Outputs are sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    mon(0, busy0, done0, stim0, err_count0, fail_vec0, pass0);
    mon(1, busy1, done1, stim1, err_count1, fail_vec1, pass1);
  end

  function automatic logic cur_done(input int d);
    return (d == 0) ? done0 : done1;
  endfunction

  function automatic logic [W-1:0] cur_stim(input int d);
    return (d == 0) ? stim0 : stim1;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v;
    else        start1 = v;
  endtask

  task automatic check_all_zero(input int d, input string tag);
    if (d == 0) begin
      check_output({tag, " dut0 stim"},      32'(stim0), 0);
      check_output({tag, " dut0 busy"},      32'(busy0), 0);
      check_output({tag, " dut0 done"},      32'(done0), 0);
      check_output({tag, " dut0 pass"},      32'(pass0), 0);
      check_output({tag, " dut0 err_count"}, 32'(err_count0), 0);
      check_output({tag, " dut0 fail_vec"},  32'(fail_vec0), 0);
    end else begin
      check_output({tag, " dut1 stim"},      32'(stim1), 0);
      check_output({tag, " dut1 busy"},      32'(busy1), 0);
      check_output({tag, " dut1 done"},      32'(done1), 0);
      check_output({tag, " dut1 pass"},      32'(pass1), 0);
      check_output({tag, " dut1 err_count"}, 32'(err_count1), 0);
      check_output({tag, " dut1 fail_vec"},  32'(fail_vec1), 0);
    end
  endtask

  // One sweep: load the response table, queue the expectation, pulse start,
  // optionally re-pulse start when the sweep reaches repulse_vec, then wait
  // (bounded) for done and confirm the result is held while idle.
  task automatic apply_stimulus(input int d, input logic [N-1:0] tab, input int repulse_vec);
    exp_t e;
    int   k;
    int   pulsed;
    int   idle;
    e = model(tab, (d == 0) ? S0 : S1);
    if (d == 0) begin tab0 = tab; q0.push_back(e); end
    else        begin tab1 = tab; q1.push_back(e); end
    @(negedge clk);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    pulsed = 0;
    for (k = 0; k < 200 && !cur_done(d); k++) begin
      if (pulsed == 1) begin
        set_start(d, 1'b0);
        pulsed = 2;
      end else if (pulsed == 0 && repulse_vec >= 0 && cur_stim(d) == W'(repulse_vec)) begin
        set_start(d, 1'b1);
        pulsed = 1;
      end
      @(negedge clk);
    end
    set_start(d, 1'b0);
    if (k >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout dut%0d: done=0 after %0d cycles, expected done=1", d, k);
    end else begin
      idle = $urandom_range(1, 3);
      repeat (idle) @(negedge clk);
      if (d == 0) begin
        check_output("dut0 done_held", 32'(done0), 1);
        check_output("dut0 err_held", 32'(err_count0), e.err);
      end else begin
        check_output("dut1 done_held", 32'(done1), 1);
        check_output("dut1 err_held", 32'(err_count1), e.err);
      end
    end
  endtask

  // Start a sweep, assert reset asynchronously once vector 2 is on stim,
  // verify everything clears, then release reset and rerun cleanly.
  task automatic reset_mid_sweep(input int d);
    int k;
    if (d == 0) tab0 = 4'b0111;
    else        tab1 = 4'b0111;
    @(negedge clk);
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    for (k = 0; k < 50 && cur_stim(d) != W'(2); k++) @(negedge clk);
    if (k >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL reach_vec2 dut%0d: stim=%0d, expected 2", d, cur_stim(d));
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero(0, "midreset");
    check_all_zero(1, "midreset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    apply_stimulus(d, 4'b0111, -1);
  endtask

  // Hold start high across the FIN cycle: the FIN edge must ignore it and
  // the following idle edge must accept it, giving two full sweeps.
  task automatic start_held_over_fin();
    exp_t e;
    int   k;
    e = model(4'b0111, S0);
    tab0 = 4'b0111;
    q0.push_back(e);
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    for (k = 0; k < 100 && !done0; k++) @(negedge clk);
    for (k = 0; k < 100 && !busy0; k++) @(negedge clk);
    start0 = 1'b0;
    for (k = 0; k < 100 && !done0; k++) @(negedge clk);
    if (k >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL back_to_back: done=0 after second sweep window, expected done=1");
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rtab;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    tab0   = 4'b0111;
    tab1   = 4'b0111;
    for (int d = 0; d < 2; d++) begin
      prev_busy[d] = 1'b0;
      prev_done[d] = 1'b0;
      cyc[d]       = 0;
      seen_n[d]    = 0;
      seen_sig[d]  = 0;
      last_v[d]    = '0;
    end
    #13;
    check_all_zero(0, "reset");
    check_all_zero(1, "reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] correct NAND sweep");
    apply_stimulus(0, 4'b0111, -1);
    $display("[TB] inverted function");
    apply_stimulus(0, 4'b1000, -1);
    $display("[TB] response stuck at 1");
    apply_stimulus(0, 4'b1111, -1);
    $display("[TB] response stuck at 0");
    apply_stimulus(0, 4'b0000, -1);
    $display("[TB] start re-pulsed at vector 01");
    apply_stimulus(0, 4'b0111, 1);
    $display("[TB] start held across completion");
    start_held_over_fin();
    $display("[TB] reset mid sweep, SETTLE=1");
    reset_mid_sweep(0);
    $display("[TB] reset mid sweep, SETTLE=3");
    reset_mid_sweep(1);
    apply_stimulus(1, 4'b0000, -1);

    $display("[TB] randomized response tables");
    for (int i = 0; i < 10; i++) begin
      rtab = N'($urandom);
      apply_stimulus(i % 2, rtab, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, N - 1)) : -1);
    end

    repeat (3) @(negedge clk);
    check_output("dut0 queue_drained", q0.size(), 0);
    check_output("dut1 queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
